// File: rtl/pattern_history_table_if.sv
// Lookup/update/prediction bundle between the gshare front end and the pattern history table.
interface pattern_history_table_if #(
    parameter int unsigned G_WIDTH = 7
);
    logic             lookupValid;
    logic [G_WIDTH:0] index;
    logic             updateValid;
    logic [G_WIDTH:0] updateIndex;
    logic             updateTaken;
    logic             ready;
    logic             predValid;
    logic             predictTaken;
    logic [1:0]       predCounter;

    modport master (
        output lookupValid, index, updateValid, updateIndex, updateTaken,
        input  ready, predValid, predictTaken, predCounter
    );

    modport slave (
        input  lookupValid, index, updateValid, updateIndex, updateTaken,
        output ready, predValid, predictTaken, predCounter
    );
endinterface

// File: rtl/pattern_history_table.sv
// Gshare pattern history table: 2-bit saturating counters, registered lookup,
// two-stage read-modify-write update with forwarding, init sweep after reset.
module pattern_history_table #(
    parameter int unsigned G_WIDTH  = 7,
    parameter logic [1:0]  INIT_CTR = 2'b01
) (
    input  logic                    clk,
    input  logic                    reset,
    pattern_history_table_if.slave  bus
);
    localparam int unsigned IW    = G_WIDTH + 1;
    localparam int unsigned DEPTH = 2 ** IW;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic            ready_q, ready_d;
    logic            pred_valid_q, pred_valid_d;
    logic [1:0]      pred_ctr_q, pred_ctr_d;

    // U1 stage: captured update plus the counter value it will modify
    logic            u1_valid_q, u1_valid_d;
    logic [IW-1:0]   u1_idx_q, u1_idx_d;
    logic            u1_taken_q, u1_taken_d;
    logic [1:0]      u1_old_q, u1_old_d;

    logic [1:0]      mem_q [DEPTH];

    logic            wr_en_c;
    logic [IW-1:0]   wr_idx_c;
    logic [1:0]      wr_data_c;

    function automatic logic [1:0] sat_ctr(input logic [1:0] old, input logic taken);
        if (taken) begin
            return (old == 2'b11) ? 2'b11 : old + 2'b01;
        end
        return (old == 2'b00) ? 2'b00 : old - 2'b01;
    endfunction

    // Single array write port: sweep writes in INIT, U2 writes in READY; none on a reset edge
    always_comb begin
        wr_en_c   = 1'b0;
        wr_idx_c  = ptr_q;
        wr_data_c = INIT_CTR;
        if (!reset) begin
            if (state_q == ST_INIT) begin
                wr_en_c = 1'b1;
            end else if (u1_valid_q) begin
                wr_en_c   = 1'b1;
                wr_idx_c  = u1_idx_q;
                wr_data_c = sat_ctr(u1_old_q, u1_taken_q);
            end
        end
    end

    // Next-state, lookup and U1 capture
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        ready_d      = ready_q;
        pred_valid_d = 1'b0;
        pred_ctr_d   = pred_ctr_q;
        u1_valid_d   = 1'b0;
        u1_idx_d     = u1_idx_q;
        u1_taken_d   = u1_taken_q;
        u1_old_d     = u1_old_q;

        case (state_q)
            ST_INIT: begin
                ptr_d = ptr_q + IW'(1);
                if (ptr_q == IW'(DEPTH - 1)) begin
                    state_d = ST_READY;
                    ready_d = 1'b1;
                end
            end
            ST_READY: begin
                if (bus.lookupValid) begin
                    pred_valid_d = 1'b1;
                    pred_ctr_d   = (wr_en_c && (wr_idx_c == bus.index)) ? wr_data_c
                                                                        : mem_q[bus.index];
                end
                if (bus.updateValid) begin
                    u1_valid_d = 1'b1;
                    u1_idx_d   = bus.updateIndex;
                    u1_taken_d = bus.updateTaken;
                    // A write landing on this edge is newer than the array contents
                    u1_old_d   = (wr_en_c && (wr_idx_c == bus.updateIndex)) ? wr_data_c
                                                                            : mem_q[bus.updateIndex];
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase

        if (reset) begin
            state_d      = ST_INIT;
            ptr_d        = IW'(0);
            ready_d      = 1'b0;
            pred_valid_d = 1'b0;
            pred_ctr_d   = 2'b00;
            u1_valid_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        state_q      <= state_d;
        ptr_q        <= ptr_d;
        ready_q      <= ready_d;
        pred_valid_q <= pred_valid_d;
        pred_ctr_q   <= pred_ctr_d;
        u1_valid_q   <= u1_valid_d;
        u1_idx_q     <= u1_idx_d;
        u1_taken_q   <= u1_taken_d;
        u1_old_q     <= u1_old_d;
    end

    // Counter array has no reset; the sweep initialises it
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem_q[wr_idx_c] <= wr_data_c;
        end
    end

    assign bus.ready        = ready_q;
    assign bus.predValid    = pred_valid_q;
    assign bus.predCounter  = pred_ctr_q;
    assign bus.predictTaken = pred_ctr_q[1];
endmodule

// File: tb/tb_pattern_history_table.sv
// Self-checking bench for pattern_history_table: table vectors, init/reset sequences,
// and randomized traffic against a behavioural counter-array model.
module tb_pattern_history_table;
    localparam int unsigned GW    = 7;
    localparam int unsigned DEPTH = 256;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pattern_history_table_if #(.G_WIDTH(GW)) bus ();

    pattern_history_table #(.G_WIDTH(GW), .INIT_CTR(2'b01)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: architectural counters plus one pending update
    int m_arr [DEPTH];
    bit m_ready  = 1'b0;
    int m_cnt    = 0;
    bit m_pend_v = 1'b0;
    int m_pend_i = 0;
    bit m_pend_t = 1'b0;
    bit m_pv     = 1'b0;
    int m_ctr    = 0;

    typedef struct {
        bit         lv;
        logic [7:0] li;
        bit         uv;
        logic [7:0] ui;
        bit         ut;
        bit         exp_pv;
        int         exp_ctr;
    } vec_t;

    vec_t vecs [$];

    function automatic vec_t mk(bit lv, logic [7:0] li, bit uv, logic [7:0] ui, bit ut,
                                bit exp_pv, int exp_ctr);
        vec_t v;
        v.lv = lv; v.li = li; v.uv = uv; v.ui = ui; v.ut = ut;
        v.exp_pv = exp_pv; v.exp_ctr = exp_ctr;
        return v;
    endfunction

    function automatic int sat(int c, bit taken);
        if (taken) return (c + 1 > 3) ? 3 : c + 1;
        return (c - 1 < 0) ? 0 : c - 1;
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(bit lv, int li, bit uv, int ui, bit ut);
        bus.lookupValid = lv;
        bus.index       = 8'(li);
        bus.updateValid = uv;
        bus.updateIndex = 8'(ui);
        bus.updateTaken = ut;
    endtask

    // One clock: advance the model with the sampled inputs, then compare after the edge
    task automatic tick();
        bit lv, uv, ut, rs;
        int li, ui;
        lv = bus.lookupValid; li = int'(bus.index);
        uv = bus.updateValid; ui = int'(bus.updateIndex); ut = bus.updateTaken;
        rs = reset;
        @(posedge clk);
        if (rs) begin
            m_ready = 1'b0; m_cnt = 0; m_pend_v = 1'b0; m_pv = 1'b0; m_ctr = 0;
        end else if (!m_ready) begin
            m_pv = 1'b0;
            m_cnt++;
            if (m_cnt == DEPTH) begin
                m_ready = 1'b1;
                foreach (m_arr[i]) m_arr[i] = 1;
            end
        end else begin
            if (m_pend_v) m_arr[m_pend_i] = sat(m_arr[m_pend_i], m_pend_t);
            m_pv = lv;
            if (lv) m_ctr = m_arr[li];
            m_pend_v = uv; m_pend_i = ui; m_pend_t = ut;
        end
        #1;
        chk("ready", int'(bus.ready), int'(m_ready));
        chk("predValid", int'(bus.predValid), int'(m_pv));
        chk("predCounter", int'(bus.predCounter), m_ctr);
        chk("predictTaken", int'(bus.predictTaken), (m_ctr >> 1) & 1);
    endtask

    // Bounded wait for ready; returns number of clocks taken
    task automatic wait_ready(input int limit, output int n);
        n = 0;
        while (!bus.ready && n < limit) begin
            tick();
            n++;
        end
        if (!bus.ready) begin
            errors++;
            $display("FAIL ready_timeout: got ready=0 after %0d cycles, required ready=1", n);
        end
    endtask

    initial begin
        int n;
        reset = 1'b1;
        drive(0, 0, 0, 0, 0);
        repeat (3) tick();
        chk("reset_ready", int'(bus.ready), 0);
        chk("reset_predValid", int'(bus.predValid), 0);
        chk("reset_predCounter", int'(bus.predCounter), 0);
        chk("reset_predictTaken", int'(bus.predictTaken), 0);

        // Init sweep with lookups held high
        reset = 1'b0;
        for (int k = 1; k <= int'(DEPTH); k++) begin
            drive(1, $urandom_range(0, 255), 0, 0, 0);
            tick();
            if (k < int'(DEPTH)) begin
                chk("init_ready_low", int'(bus.ready), 0);
                chk("init_predValid_low", int'(bus.predValid), 0);
            end
        end
        chk("init_ready_at_256", int'(bus.ready), 1);
        drive(1, 8'h77, 0, 0, 0);
        tick();
        chk("post_init_pv", int'(bus.predValid), 1);
        chk("post_init_ctr", int'(bus.predCounter), 1);
        chk("post_init_taken", int'(bus.predictTaken), 0);

        // Directed vectors: saturation, forwarding, bypass, independence
        for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 0, 1, 8'h3C, 1, 0, 0));
        vecs.push_back(mk(1, 8'h3C, 0, 0, 0, 1, 3));
        for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 0, 1, 8'h3C, 0, 0, 0));
        vecs.push_back(mk(1, 8'h3C, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 8'h05, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 8'h05, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 8'h05, 0, 0, 0, 1, 3));
        vecs.push_back(mk(1, 8'hA0, 1, 8'hA0, 1, 1, 1));
        vecs.push_back(mk(1, 8'hA0, 0, 0, 0, 1, 2));
        vecs.push_back(mk(1, 8'hA0, 0, 0, 0, 1, 2));
        vecs.push_back(mk(1, 8'h12, 1, 8'h11, 1, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 8'h11, 0, 0, 0, 1, 2));
        vecs.push_back(mk(1, 8'h3C, 0, 0, 0, 1, 0));
        foreach (vecs[i]) begin
            drive(vecs[i].lv, int'(vecs[i].li), vecs[i].uv, int'(vecs[i].ui), vecs[i].ut);
            tick();
            chk($sformatf("vec%0d_pv", i), int'(bus.predValid), int'(vecs[i].exp_pv));
            if (vecs[i].exp_pv) begin
                chk($sformatf("vec%0d_ctr", i), int'(bus.predCounter), vecs[i].exp_ctr);
                chk($sformatf("vec%0d_taken", i), int'(bus.predictTaken), vecs[i].exp_ctr / 2);
            end
        end

        // Randomized traffic; narrow index range forces collisions
        for (int c = 0; c < 2000; c++) begin
            int li, ui;
            li = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 7);
            ui = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 7);
            drive($urandom_range(0, 1), li, $urandom_range(0, 2) != 0, ui, $urandom_range(0, 1));
            tick();
        end

        // Reset in READY with an update in flight
        drive(0, 0, 1, 8'h40, 1);
        tick();
        reset = 1'b1;
        tick();
        chk("ready_reset_ready", int'(bus.ready), 0);
        chk("ready_reset_ctr", int'(bus.predCounter), 0);
        reset = 1'b0;
        drive(1, 8'h40, 0, 0, 0);
        wait_ready(400, n);
        chk("reinit_latency", n, 256);

        // Reset mid-sweep with updates issued during INIT
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(1, 8'h3C, 1, 8'h3C, 1);
        repeat (100) tick();
        chk("midsweep_ready_low", int'(bus.ready), 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        wait_ready(400, n);
        chk("midsweep_latency", n, 256);
        drive(1, 8'h3C, 0, 0, 0);
        tick();
        chk("init_update_dropped_pv", int'(bus.predValid), 1);
        chk("init_update_dropped_ctr", int'(bus.predCounter), 1);
        drive(1, 8'h40, 0, 0, 0);
        tick();
        chk("inflight_dropped_ctr", int'(bus.predCounter), 1);
        drive(0, 0, 0, 0, 0);
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pattern_history_table.md
# pattern_history_table

Gshare pattern history table (PHT) that consumes the index formed from global history XOR PC. It holds 2^(G_WIDTH+1) two-bit saturating counters and returns a registered taken/not-taken prediction for each lookup. It accepts resolved-branch updates from the execute/commit side through a two-stage read-modify-write pipeline, with forwarding. After reset it runs a sweep that initialises every counter before declaring itself ready.

## Interface

- G_WIDTH, 7, index MSB; index width G_WIDTH+1, table depth 2^(G_WIDTH+1) (256 entries by default)
- INIT_CTR, 2'b01, counter value written to every entry during the init sweep (weakly not-taken)

- clk  in  1  clock; all state updates on posedge
- reset  in  1  reset, synchronous, active-high
- lookupValid  in  1  prediction request this cycle
- index  in  G_WIDTH+1  lookup index from the gshare index generator
- updateValid  in  1  resolved conditional branch this cycle
- updateIndex  in  G_WIDTH+1  index the branch was predicted with
- updateTaken  in  1  resolved outcome, 1 = taken
- ready  out  1  table initialised; lookups and updates honoured
- predValid  out  1  predictTaken/predCounter valid this cycle
- predictTaken  out  1  MSB of the looked-up counter
- predCounter  out  2  looked-up counter value, for debug and for a confidence consumer

## Operation

- FSM states are INIT and READY.
  - reset forces INIT and sets sweep pointer = 0.
  - In INIT, each cycle writes INIT_CTR to entry[ptr] and then increments ptr.
  - When ptr = 2^(G_WIDTH+1)-1 is written, the next state is READY.
- In INIT:
  - ready = 0, predValid = 0.
  - lookupValid and updateValid are ignored and dropped, not queued.
- Lookup (READY only):
  - Sampled at edge N.
  - After edge N: predValid = 1, predCounter = ctr[index] including forwarding, predictTaken = predCounter[1].
  - With no lookup, predValid = 0 and predictTaken/predCounter hold their last values.
- Update pipeline (READY only):
  - U1 registers {updateIndex, updateTaken} at edge N.
  - During cycle N+1, U2 computes new = sat(old, taken) and writes it into the array at edge N+1.
- Saturating rule:
  - taken: new = (old == 3) ? 3 : old+1.
  - not-taken: new = (old == 0) ? 0 : old-1.
  - 2-bit arithmetic only; no wrap.
- Forwarding:
  - U2 old value: if a write of the same index is committing at the edge that U1 was loaded, use that written value rather than the array. Back-to-back updates to the same index therefore accumulate; two takens from 01 give 11.
  - Lookup bypass: if a lookup is sampled at the same edge as a U2 write to the same index, the lookup returns the newly written value.
- An update and a lookup may both be valid in the same cycle, to the same index or different indices. Both are honoured.

## Timing

- Reset values: ready = 0, predValid = 0, predictTaken = 0, predCounter = 2'b00; U1/U2 valid = 0; FSM = INIT, ptr = 0.
- The array is not cleared by reset itself; the sweep clears it.
- Init latency: ready rises 2^(G_WIDTH+1) cycles after the first edge with reset low (256 cycles by default).
- Reset asserted mid-sweep or in READY:
  - Abort immediately.
  - Drop in-flight updates; no U2 write on that edge.
  - Restart the sweep from entry 0.
- Lookup latency: 1 cycle, registered output. Throughput is one lookup per cycle.
- Update latency:
  - Sampled at edge N, written at edge N+1.
  - Visible to a lookup sampled at edge N+1 via the bypass, and to later lookups via the array.
  - A lookup sampled at edge N, the same edge the update was sampled, sees the pre-update value.
- Update throughput: one per cycle with no stall. There is no backpressure output.

## Test plan

- Init: deassert reset, hold lookupValid=1 → ready=0 and predValid=0 for 256 cycles. ready=1 on cycle 256. Then any lookup → predCounter=01, predictTaken=0.
- Saturation up/down:
  - Four taken updates to 0x3C, then a lookup → predCounter=11, predictTaken=1.
  - Then five not-taken updates, then a lookup → predCounter=00.
- Back-to-back forwarding: taken updates to 0x05 on consecutive cycles N and N+1 → lookup at N+3 returns 11, not 10.
- Lookup bypass: update 0xA0 taken sampled at edge N, lookup 0xA0 at edge N+1 → predCounter=10. A lookup to 0xA0 at edge N instead → 01.
- Independence: a simultaneous update to 0x11 (taken) and lookup of 0x12 → lookup returns 01, and 0x11 later reads 10.
- Reset mid-sweep: pulse reset at sweep cycle 100 → ready stays low until 256 cycles after release. Updates issued during INIT leave their entries at 01.
